rv_div_ctrl: RTL and testbench

Divide-unit controller for the RV64 M-extension. It accepts DIV/DIVU/REM/REMU and their W forms from the execute stage. Divide-by-zero and signed overflow are resolved locally. All other operations are issued to the radix-4 SRT divider core, with operands extended to XLEN+1 bits, and the core's quotient or remainder is returned to writeback through a valid/ready response port. One operation is outstanding at a time.

---
 rtl/rv_div_ctrl_pkg.sv | 36 +++
 rtl/rv_div_prep.sv | 32 +++
 rtl/rv_div_ctrl.sv | 156 +++++++++++++++
 tb/tb_rv_div_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_div_ctrl_pkg.sv
// Shared constants, FSM encoding and result formatting for the RV64 divide-unit controller.
package rv_div_ctrl_pkg;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  localparam logic [2:0] DIV_F3  = 3'b100;
  localparam logic [2:0] DIVU_F3 = 3'b101;
  localparam logic [2:0] REM_F3  = 3'b110;
  localparam logic [2:0] REMU_F3 = 3'b111;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ISSUE = 5'b00010,
    S_BUSY  = 5'b00100,
    S_DONE  = 5'b01000,
    S_DRAIN = 5'b10000
  } div_state_e;

  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == DIV_F3) || (f3 == REM_F3);
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == REM_F3) || (f3 == REMU_F3);
  endfunction

  // W forms always sign-extend bit 31, including DIVUW/REMUW.
  function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN:0] quo, input logic [XLEN:0] rem,
                                                 input logic is_rem, input logic w);
    logic [XLEN:0] r;
    r = is_rem ? rem : quo;
    return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r[XLEN-1:0];
  endfunction

endpackage

// File: rtl/rv_div_prep.sv
// Operand extension to XLEN+1 bits, W masking and divide-by-zero / signed-overflow detection.
module rv_div_prep
  import rv_div_ctrl_pkg::*;
(
  input  logic [2:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN:0]   ext_op1,
  output logic [XLEN:0]   ext_op2,
  output logic            is_zero,
  output logic            is_ovf
);

  logic sgn;

  always_comb begin
    sgn = f3_is_signed(op);
    if (w) begin
      ext_op1 = {{(XLEN-31){sgn & op1[31]}}, op1[31:0]};
      ext_op2 = {{(XLEN-31){sgn & op2[31]}}, op2[31:0]};
    end else begin
      ext_op1 = {sgn & op1[XLEN-1], op1};
      ext_op2 = {sgn & op2[XLEN-1], op2};
    end
    is_zero = (ext_op2 == '0);
    // A signed -1 divisor extends to all ones at either width.
    is_ovf  = sgn && (ext_op2 == '1) &&
              (w ? (op1[31:0] == 32'h8000_0000) : (op1 == {1'b1, {(XLEN-1){1'b0}}}));
  end

endmodule

// File: rtl/rv_div_ctrl.sv
// RV64 M-extension divide controller: resolves special cases locally, otherwise drives the SRT core.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module rv_div_ctrl
  import rv_div_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_vld_i,
  output logic             req_rdy_o,
  input  logic [2:0]       req_op_i,
  input  logic             req_w_i,
  input  logic [XLEN-1:0]  req_op1_i,
  input  logic [XLEN-1:0]  req_op2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             resp_vld_o,
  input  logic             resp_rdy_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             core_vld_o,
  output logic [XLEN:0]    core_op1_o,
  output logic [XLEN:0]    core_op2_o,
  input  logic             core_rdy_i,
  input  logic [XLEN:0]    core_quo_i,
  input  logic [XLEN:0]    core_rem_i
);

  div_state_e    state_q, state_d;
  logic [XLEN:0] prep_op1, prep_op2;
  logic          prep_zero, prep_ovf;
  logic          rem_q, w_q, seen_low_q;
  logic          accept, special, cache_hit, capture, core_rise;
  logic [XLEN:0] cache_quo, cache_rem, local_quo, local_rem;

  rv_div_prep u_prep (
    .op      (req_op_i),
    .w       (req_w_i),
    .op1     (req_op1_i),
    .op2     (req_op2_i),
    .ext_op1 (prep_op1),
    .ext_op2 (prep_op2),
    .is_zero (prep_zero),
    .is_ovf  (prep_ovf)
  );

  assign req_rdy_o = (state_q == S_IDLE);
  assign accept    = req_vld_i & req_rdy_o & ~flush_i;
  assign special   = prep_zero | prep_ovf;
  assign core_rise = core_rdy_i & seen_low_q;

`ifdef DIV_RESULT_CACHE_EN
  logic          cache_vld_q, cache_w_q, cache_sgn_q, key_sgn_q;
  logic [XLEN:0] cache_op1_q, cache_op2_q, cache_quo_q, cache_rem_q;

  assign cache_hit = cache_vld_q && (cache_op1_q == prep_op1) && (cache_op2_q == prep_op2) &&
                     (cache_w_q == req_w_i) && (cache_sgn_q == f3_is_signed(req_op_i));
  assign cache_quo = cache_quo_q;
  assign cache_rem = cache_rem_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  cache_vld_q <= 1'b0;
    else if (state_q == S_DRAIN) cache_vld_q <= 1'b0;
    else if (capture)            cache_vld_q <= 1'b1;
  end

  // NOTE: payload needs no reset; the valid bit alone gates every use of it.
  always_ff @(posedge clk) begin
    if (accept) key_sgn_q <= f3_is_signed(req_op_i);
    if (capture) begin
      cache_op1_q <= core_op1_o;
      cache_op2_q <= core_op2_o;
      cache_w_q   <= w_q;
      cache_sgn_q <= key_sgn_q;
      cache_quo_q <= core_quo_i;
      cache_rem_q <= core_rem_i;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_quo = '0;
  assign cache_rem = '0;
`endif

  // Result available without the core: divide-by-zero, overflow, or a cache hit.
  always_comb begin
    local_quo = '1;
    local_rem = prep_op1;
    if (prep_ovf) begin
      local_quo = prep_op1;
      local_rem = '0;
    end
    if (!special) begin
      local_quo = cache_quo;
      local_rem = cache_rem;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = (special || cache_hit) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (flush_i)         state_d = core_rdy_i ? S_DRAIN : S_IDLE;
        else if (core_rdy_i) state_d = S_BUSY;
      end
      S_BUSY: begin
        // A flush landing on the return cycle has nothing left to drain.
        if (core_rise) begin
          capture = ~flush_i;
          state_d = flush_i ? S_IDLE : S_DONE;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  if (flush_i || resp_rdy_i) state_d = S_IDLE;
      S_DRAIN: if (core_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rem_q       <= 1'b0;
      w_q         <= 1'b0;
      seen_low_q  <= 1'b0;
      resp_vld_o  <= 1'b0;
      resp_data_o <= '0;
      resp_tag_o  <= '0;
      core_vld_o  <= 1'b0;
      core_op1_o  <= '0;
      core_op2_o  <= '0;
    end else begin
      state_q    <= state_d;
      core_vld_o <= (state_d == S_ISSUE);
      resp_vld_o <= (state_d == S_DONE);
      if (state_q inside {S_BUSY, S_DRAIN}) seen_low_q <= seen_low_q | ~core_rdy_i;
      else                                  seen_low_q <= 1'b0;
      if (accept) begin
        rem_q      <= f3_is_rem(req_op_i);
        w_q        <= req_w_i;
        resp_tag_o <= req_tag_i;
        core_op1_o <= prep_op1;
        core_op2_o <= prep_op2;
      end
      if (accept && state_d == S_DONE)
        resp_data_o <= fmt_result(local_quo, local_rem, f3_is_rem(req_op_i), req_w_i);
      else if (capture)
        resp_data_o <= fmt_result(core_quo_i, core_rem_i, rem_q, w_q);
    end
  end

endmodule

// File: tb/tb_rv_div_ctrl.sv
// Directed bench for rv_div_ctrl with a fixed-latency SRT core model.
module tb_rv_div_ctrl;

  localparam int CORE_LAT      = 4;
  localparam int CORE_PATH_LAT = CORE_LAT + 3;
`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_ISS = 0;
`else
  localparam int HIT_LAT = CORE_PATH_LAT;
  localparam int HIT_ISS = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_vld, req_rdy_o, req_w, flush, resp_rdy, resp_vld_o, core_vld_o;
  logic [2:0]  req_op;
  logic [63:0] req_op1, req_op2, resp_data_o;
  logic [4:0]  req_tag, resp_tag_o;
  logic [64:0] core_op1_o, core_op2_o, core_quo, core_rem;
  logic        core_rdy;

  logic signed [64:0] core_a, core_b;
  int core_cnt;
  int issue_cnt;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rv_div_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_vld_i   (req_vld),
    .req_rdy_o   (req_rdy_o),
    .req_op_i    (req_op),
    .req_w_i     (req_w),
    .req_op1_i   (req_op1),
    .req_op2_i   (req_op2),
    .req_tag_i   (req_tag),
    .flush_i     (flush),
    .resp_vld_o  (resp_vld_o),
    .resp_rdy_i  (resp_rdy),
    .resp_data_o (resp_data_o),
    .resp_tag_o  (resp_tag_o),
    .core_vld_o  (core_vld_o),
    .core_op1_o  (core_op1_o),
    .core_op2_o  (core_op2_o),
    .core_rdy_i  (core_rdy),
    .core_quo_i  (core_quo),
    .core_rem_i  (core_rem)
  );

  // Core model: accepts while ready, stays busy CORE_LAT cycles, then presents results.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_rdy  <= 1'b1;
      core_cnt  <= 0;
      core_quo  <= '0;
      core_rem  <= '0;
      issue_cnt <= 0;
    end else if (core_rdy) begin
      if (core_vld_o) begin
        core_rdy  <= 1'b0;
        core_cnt  <= CORE_LAT;
        core_a    <= core_op1_o;
        core_b    <= core_op2_o;
        issue_cnt <= issue_cnt + 1;
      end
    end else if (core_cnt == 1) begin
      core_rdy <= 1'b1;
      core_quo <= core_a / core_b;
      core_rem <= core_a % core_b;
    end else begin
      core_cnt <= core_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp, input int exp_lat, input int exp_iss, input int hold);
    int lat, iss0, n;
    logic [63:0] d0;
    logic [4:0]  t0;
    logic        stable;
    iss0 = issue_cnt;
    @(negedge clk);
    n = 0;
    while (!req_rdy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_vld = 1'b1; req_op = op; req_w = w; req_op1 = a; req_op2 = b; req_tag = tag;
    @(negedge clk);
    req_vld = 1'b0;
    check({name, "_rdy_drop"}, 64'(req_rdy_o), 64'd0);
    lat = 1;
    while (!resp_vld_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_data"}, resp_data_o, exp);
    check({name, "_tag"}, 64'(resp_tag_o), 64'(tag));
    d0 = resp_data_o;
    t0 = resp_tag_o;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_vld_o !== 1'b1 || resp_data_o !== d0 || resp_tag_o !== t0) stable = 1'b0;
    end
    if (hold > 0) check({name, "_hold_stable"}, 64'(stable), 64'd1);
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    check({name, "_rdy_back"}, 64'(req_rdy_o), 64'd1);
    check({name, "_vld_drop"}, 64'(resp_vld_o), 64'd0);
    check({name, "_issues"}, 64'(issue_cnt - iss0), 64'(exp_iss));
  endtask

  initial begin
    int  n;
    logic seen;
    rstn = 1'b0; req_vld = 1'b0; req_op = 3'b100; req_w = 1'b0; req_op1 = '0; req_op2 = '0;
    req_tag = '0; flush = 1'b0; resp_rdy = 1'b0;
    #12;
    check("rst_resp_vld", 64'(resp_vld_o), 64'd0);
    check("rst_resp_data", resp_data_o, 64'd0);
    check("rst_resp_tag", 64'(resp_tag_o), 64'd0);
    check("rst_core_vld", 64'(core_vld_o), 64'd0);
    check("rst_core_op1", core_op1_o[63:0], 64'd0);
    check("rst_core_op2", core_op2_o[63:0], 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_req_rdy", 64'(req_rdy_o), 64'd1);

    // Core path, signed
    run_op("div_m7_2", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1,
           64'hFFFF_FFFF_FFFF_FFFD, CORE_PATH_LAT, 1, 0);
    run_op("rem_m7_2", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2,
           64'hFFFF_FFFF_FFFF_FFFF, HIT_LAT, HIT_ISS, 0);
    // Core path, unsigned and W with garbage upper bits
    run_op("divu_big", 3'b101, 1'b0, 64'h8000_0000_0000_0000, 64'd3, 5'd4,
           64'h2AAA_AAAA_AAAA_AAAA, CORE_PATH_LAT, 1, 0);
    run_op("divuw", 3'b101, 1'b1, 64'hDEAD_BEEF_FFFF_FFFF, 64'd2, 5'd5,
           64'h0000_0000_7FFF_FFFF, CORE_PATH_LAT, 1, 0);
    // Divide by zero
    run_op("div_by0", 3'b100, 1'b0, 64'd5, 64'd0, 5'd6,
           64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
    run_op("remw_by0", 3'b110, 1'b1, 64'h0000_0001_8000_0001, 64'd0, 5'd7,
           64'hFFFF_FFFF_8000_0001, 1, 0, 0);
    run_op("divuw_mask0", 3'b101, 1'b1, 64'd7, 64'h0000_0001_0000_0000, 5'd8,
           64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
    // Signed overflow
    run_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
           64'h8000_0000_0000_0000, 1, 0, 0);
    run_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
           64'd0, 1, 0, 0);
    run_op("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd13,
           64'hFFFF_FFFF_8000_0000, 1, 0, 0);

    // Flush two cycles after ISSUE: drain the core, no response.
    @(negedge clk);
    req_vld = 1'b1; req_op = 3'b100; req_w = 1'b0; req_op1 = 64'd50; req_op2 = 64'd5; req_tag = 5'd3;
    @(negedge clk);
    req_vld = 1'b0;
    check("flush_issue_pulse", 64'(core_vld_o), 64'd1);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_drain_rdy", 64'(req_rdy_o), 64'd0);
    seen = resp_vld_o;
    n = 0;
    while (!req_rdy_o && n < 50) begin
      @(negedge clk);
      n++;
      if (resp_vld_o) seen = 1'b1;
    end
    check("flush_rdy_lat", 64'(n), 64'd3);
    check("flush_core_rdy", 64'(core_rdy), 64'd1);
    repeat (2) begin
      @(negedge clk);
      if (resp_vld_o) seen = 1'b1;
    end
    check("flush_no_resp", 64'(seen), 64'd0);

    run_op("div_100_7", 3'b100, 1'b0, 64'd100, 64'd7, 5'd9, 64'd14, CORE_PATH_LAT, 1, 0);
    run_op("rem_100_7", 3'b110, 1'b0, 64'd100, 64'd7, 5'd10, 64'd2, HIT_LAT, HIT_ISS, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
